// File: rtl/sum_pipe_pkg.sv
// sum_pipe_pkg: constants and the 4-bit carry-lookahead group shared by the pipeline stages.
package sum_pipe_pkg;

    localparam int GROUP = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef struct packed {
        logic             cout;
        logic [GROUP-1:0] sum;
    } cla4_t;

    // One lookahead group: every carry is a flat sum of products of g/p and cin,
    // so the group depth does not grow bit by bit.
    function automatic cla4_t cla4(input logic [GROUP-1:0] x,
                                   input logic [GROUP-1:0] y,
                                   input logic             cin);
        logic [GROUP-1:0] g;
        logic [GROUP-1:0] p;
        logic [GROUP-1:0] c;
        cla4_t            r;
        g = x & y;
        p = x ^ y;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        r.cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & cin);
        r.sum = p ^ c;
        return r;
    endfunction

endpackage

// File: rtl/cla4_stage.sv
// cla4_stage: one pipeline stage resolving result bits [4K+3:4K] with its own
// stage register, valid bit and stall handling.
module cla4_stage
    import sum_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K     = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_bx,
    input  logic [WIDTH-1:0] in_s,
    input  logic             in_c,
    input  logic             down_ready,
    output logic             valid,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] bx,
    output logic [WIDTH-1:0] s,
    output logic             c
);

    localparam int LSB = K * GROUP;

    logic             advance;
    cla4_t            grp;
    logic [WIDTH-1:0] s_next;

    // The stage takes new contents when it is empty or its current contents move on.
    assign advance = !valid || down_ready;

    // Resolve this stage's group and merge it into the partial result from upstream.
    always_comb begin
        // NOTE: every variable written here gets a value on every path, so no latch is inferred.
        s_next = in_s;
        grp    = cla4(in_a[LSB +: GROUP], in_bx[LSB +: GROUP], in_c);
        s_next[LSB +: GROUP] = grp.sum;
    end

    // Stage register: load on advance, hold data and valid unchanged while stalled.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            a     <= '0;
            bx    <= '0;
            s     <= '0;
            c     <= 1'b0;
        end else if (advance) begin
            // NOTE: non-blocking assignments so every stage samples its neighbour's old value.
            valid <= in_valid;
            if (in_valid) begin
                a  <= in_a;
                bx <= in_bx;
                s  <= s_next;
                c  <= grp.cout;
            end
        end
    end

endmodule

// File: rtl/sum_pipe.sv
// sum_pipe: pipelined carry-lookahead adder/subtractor, one 4-bit group per stage,
// valid/ready handshake with full backpressure.
module sum_pipe
    import sum_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int LAT = WIDTH / GROUP;

    // Index k is the input of stage k; index k+1 is its registered output.
    logic [LAT:0]     vld;
    logic [LAT:0]     rdy;
    logic [LAT:0]     c_p;
    logic [WIDTH-1:0] a_p  [LAT+1];
    logic [WIDTH-1:0] bx_p [LAT+1];
    logic [WIDTH-1:0] s_p  [LAT+1];

    // Subtract is a + ~b + 1: invert b up front and force the initial carry.
    assign vld[0]  = in_valid;
    assign a_p[0]  = a;
    assign bx_p[0] = (op == OP_SUB) ? ~b : b;
    assign s_p[0]  = '0;
    assign c_p[0]  = (op == OP_ADD) ? c_in : 1'b1;

    // Ready chain: combinational from out_ready back to in_ready, one OR per stage.
    always_comb begin
        rdy      = '0;
        rdy[LAT] = out_ready;
        for (int k = LAT - 1; k >= 0; k--) begin
            rdy[k] = !vld[k+1] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0];

    for (genvar k = 0; k < LAT; k++) begin : stage_g
        cla4_stage #(
            .WIDTH (WIDTH),
            .K     (k)
        ) u_stage (
            .clk        (clk),
            .reset      (reset),
            .in_valid   (vld[k]),
            .in_a       (a_p[k]),
            .in_bx      (bx_p[k]),
            .in_s       (s_p[k]),
            .in_c       (c_p[k]),
            .down_ready (rdy[k+1]),
            .valid      (vld[k+1]),
            .a          (a_p[k+1]),
            .bx         (bx_p[k+1]),
            .s          (s_p[k+1]),
            .c          (c_p[k+1])
        );
    end

    assign out_valid = vld[LAT];
    assign s         = s_p[LAT];
    assign c_out     = c_p[LAT];

    // Flags only describe a result that is actually presented, so they read 0 when idle.
    assign ovf  = out_valid && (a_p[LAT][WIDTH-1] == bx_p[LAT][WIDTH-1])
                            && (s_p[LAT][WIDTH-1] != a_p[LAT][WIDTH-1]);
    assign zero = out_valid && (s_p[LAT] == '0);

endmodule
